// File: rtl/updown_cnt_arbiter.sv
// updown_cnt_arbiter: round-robin front end that shares one up/down counter
// among NREQ requesters. Each granted command becomes a single cnt_up or
// cnt_down pulse, a shadow copy of the count follows the shared counter, and
// the post-update value is returned to the winner before the next grant.
module updown_cnt_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 3,
    parameter int IDW   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ-1:0]  req_dir,
    output logic [NREQ-1:0]  req_ready,
    output logic             cnt_up,
    output logic             cnt_down,
    output logic             rsp_valid,
    output logic [IDW-1:0]   rsp_id,
    output logic [WIDTH-1:0] rsp_count,
    input  logic             rsp_ready,
    output logic             busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [IDW-1:0]   last_id_q;
    logic [IDW-1:0]   win_id_q;
    logic             win_dir_q;
    logic [WIDTH-1:0] shadow_q;
    logic             busy_q;
    logic [IDW:0]     pick;
    logic             accept;
    logic             rsp_done;

    // Round-robin search starting just above the previous winner. The far
    // candidates are visited first so the nearest valid one overwrites them.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] vld,
                                             input logic [IDW-1:0]  last);
        logic [IDW:0] r;
        int           idx;
        r = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            if (vld[idx]) r = {1'b1, IDW'(idx)};
        end
        return r;
    endfunction

    // Modulo 2^WIDTH step, matching the shared counter's natural wrap.
    function automatic logic [WIDTH-1:0] wrap_step(input logic [WIDTH-1:0] v,
                                                   input logic             up);
        return up ? v + WIDTH'(1) : v - WIDTH'(1);
    endfunction

    // Winner selection is purely combinational off the live valids, so a
    // requester that drops valid before being granted is simply skipped.
    always_comb begin
        pick = rr_pick(req_valid, last_id_q);
    end

    // Grant is offered only in IDLE and never during the reset cycle.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && !reset && pick[IDW])
            req_ready[pick[IDW-1:0]] = 1'b1;
    end

    assign accept   = (state_q == IDLE) && pick[IDW] && !reset;
    assign rsp_done = (state_q == RESP) && rsp_ready;

    // Next-state logic: one-cycle ISSUE, RESP holds until the response is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = ISSUE;
            ISSUE:                  state_d = RESP;
            RESP:    if (rsp_done)  state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Control state, arbitration pointer and shadow count; reset aborts any
    // operation in flight and realigns the shadow with the reset counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_id_q <= IDW'(NREQ - 1);
            shadow_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            if (accept)
                last_id_q <= pick[IDW-1:0];
            if (state_q == ISSUE)
                shadow_q <= wrap_step(shadow_q, win_dir_q);
        end
    end

    // Winner id and direction are data captured on the accept edge only.
    always_ff @(posedge clk) begin
        if (accept) begin
            win_id_q  <= pick[IDW-1:0];
            win_dir_q <= req_dir[pick[IDW-1:0]];
        end
    end

    // Output decode: pulses only in ISSUE, response fields only in RESP.
    always_comb begin
        cnt_up    = (state_q == ISSUE) &&  win_dir_q;
        cnt_down  = (state_q == ISSUE) && !win_dir_q;
        rsp_valid = (state_q == RESP);
        rsp_id    = (state_q == RESP) ? win_id_q : '0;
        rsp_count = (state_q == RESP) ? shadow_q : '0;
        busy      = busy_q;
    end

endmodule

// File: tb/tb_updown_cnt_arbiter.sv
// Directed testbench for updown_cnt_arbiter (NREQ=4, WIDTH=3).
module tb_updown_cnt_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_valid;
    logic [3:0] req_dir;
    logic [3:0] req_ready;
    logic       cnt_up;
    logic       cnt_down;
    logic       rsp_valid;
    logic [1:0] rsp_id;
    logic [2:0] rsp_count;
    logic       rsp_ready;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    updown_cnt_arbiter #(.NREQ(4), .WIDTH(3), .IDW(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_dir(req_dir), .req_ready(req_ready),
        .cnt_up(cnt_up), .cnt_down(cnt_down),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_count(rsp_count),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = 4'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Full single-requester operation; called at a negedge with the DUT idle.
    task automatic do_op(input int id, input logic dir, input logic [2:0] exp_cnt);
        req_valid = 4'b0;
        req_valid[id] = 1'b1;
        req_dir = dir ? 4'hf : 4'h0;
        rsp_ready = 1'b1;
        #1;
        chk("op_ready", req_ready, 32'(4'b1 << id));
        @(negedge clk);
        req_valid = 4'b0;
        chk("op_issue_up", cnt_up, dir);
        chk("op_issue_down", cnt_down, !dir);
        chk("op_issue_busy", busy, 1);
        chk("op_issue_noready", req_ready, 0);
        @(negedge clk);
        chk("op_resp_valid", rsp_valid, 1);
        chk("op_resp_id", rsp_id, id);
        chk("op_resp_count", rsp_count, exp_cnt);
        chk("op_resp_nopulse", {cnt_up, cnt_down}, 0);
        @(negedge clk);
        chk("op_idle_rsp", rsp_valid, 0);
        chk("op_idle_busy", busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 4'hf;
        req_dir = 4'hf;
        rsp_ready = 1'b1;

        // Reset state, with all requesters asking
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_count", rsp_count, 0);
        chk("rst_pulses", {cnt_up, cnt_down}, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        req_valid = 4'b0;
        @(negedge clk);

        // Single up from requester 0
        do_op(0, 1'b1, 3'd1);

        // Wrap: 7 ups from requester 1, 8th wraps to 0, then a down to 7
        do_reset();
        for (int i = 1; i <= 7; i++) do_op(1, 1'b1, 3'(i));
        do_op(1, 1'b1, 3'd0);
        do_op(1, 1'b0, 3'd7);

        // Mixed directions from zero
        do_reset();
        do_op(2, 1'b0, 3'd7);
        do_op(3, 1'b1, 3'd0);

        // Contention: all four valid, grants rotate 0,1,2,3,0
        do_reset();
        req_valid = 4'hf;
        req_dir = 4'hf;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("cont_grant", req_ready, 32'(4'b1 << (i % 4)));
            @(negedge clk);
            chk("cont_issue", {cnt_up, cnt_down, req_ready}, 6'b10_0000);
            @(negedge clk);
            chk("cont_rsp_id", rsp_id, i % 4);
            chk("cont_rsp_count", rsp_count, i + 1);
            @(negedge clk);
        end
        req_valid = 4'b0;

        // Backpressure: shadow is 5, last_id is 0; requester 1 goes up to 6
        @(negedge clk);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = 4'b0101;
        chk("bp_issue", cnt_up, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_id", rsp_id, 1);
            chk("bp_hold_count", rsp_count, 6);
            chk("bp_hold_quiet", {cnt_up, cnt_down, req_ready}, 0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_valid", rsp_valid, 1);
        @(negedge clk);
        chk("bp_done_valid", rsp_valid, 0);
        chk("bp_done_busy", busy, 0);
        #1;
        chk("bp_next_grant", req_ready, 4'b0100);
        req_valid = 4'b0;

        // Mid-operation reset: requester 1 then requester 2, reset in ISSUE
        do_reset();
        do_op(1, 1'b1, 3'd1);
        req_valid = 4'b0100;
        req_dir = 4'hf;
        @(negedge clk);
        req_valid = 4'b0;
        chk("mid_issue", cnt_up, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_pulses", {cnt_up, cnt_down}, 0);
        req_valid = 4'hf;
        #1;
        chk("mid_next_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = 4'b0;
        @(negedge clk);
        chk("mid_rsp_id", rsp_id, 0);
        chk("mid_rsp_count", rsp_count, 1);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/updown_cnt_arbiter.md
# updown_cnt_arbiter

Round-robin arbiter and sequencer that shares one 3-bit up/down counter among NREQ requesters. Each requester submits an up or down command over a valid/ready handshake. The block converts the granted command into a single one-cycle `cnt_up` or `cnt_down` pulse toward the shared counter, and keeps a shadow copy of the count. It then returns the post-update value to the winner over a response handshake, so requesters never see each other's updates interleaved.

## Interface
- `NREQ`, default 4: number of requesters, range 2..8.
- `WIDTH`, default 3: counter width; must match the shared counter.
- `IDW`, default 2: requester id width, equal to clog2(NREQ).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  NREQ  per-requester command valid.
- `req_dir`  in  NREQ  per-requester direction (1 = up, 0 = down); sampled with `req_valid`.
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero.
- `cnt_up`  out  1  increment pulse to the shared counter.
- `cnt_down`  out  1  decrement pulse to the shared counter.
- `rsp_valid`  out  1  response valid.
- `rsp_id`  out  IDW  id of the requester being answered.
- `rsp_count`  out  WIDTH  counter value after that requester's operation.
- `rsp_ready`  in  1  response accept (shared by all requesters).
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - If any `req_valid` is high, select the winner round-robin, searching upward from `last_id+1` (mod NREQ).
  - Drive `req_ready[winner]` = 1 combinationally; all other `req_ready` bits are 0.
  - The handshake completes at the clock edge where valid & ready are both high. At that edge, latch `win_id` and `win_dir`, set `last_id` = winner, and go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - Assert `cnt_up` = `win_dir` and `cnt_down` = !`win_dir`.
  - At the end of the cycle, update the shadow count: up gives shadow+1 and wraps 7→0; down gives shadow−1 and wraps 0→7. Arithmetic is modulo 2^WIDTH.
  - Go to RESP.
- **RESP**
  - `rsp_valid` = 1, `rsp_id` = `win_id`, `rsp_count` = shadow.
  - Hold all three stable until `rsp_ready`. On the handshake edge, go to IDLE.
- `req_ready` is 0 in ISSUE and RESP; new requests wait.
- `cnt_up` and `cnt_down` are never high together, and are never high outside ISSUE.
- `req_dir` is don't-care when `req_valid` is low. A requester may drop `req_valid` before it is granted; the arbiter then just skips it.
- Integration requirement: the shared counter must be reset by the same `reset`, so that the shadow count equals the counter value at all times.

## Timing
- Reset (synchronous), takes priority over everything:
  - state = IDLE, shadow = 0, `last_id` = NREQ−1 (so requester 0 wins first).
  - `cnt_up` = `cnt_down` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_count` = 0, `busy` = 0.
  - `req_ready` = 0 during the reset cycle.
- Reset asserted in ISSUE or RESP aborts the operation: no response is issued, and shadow returns to 0.
- Latency:
  - Accept edge T → pulse in cycle T+1 → `rsp_valid` from cycle T+2.
  - Minimum 3 cycles per operation when `rsp_ready` is tied high.
- `busy` is registered. It is high from the cycle after accept through the cycle in which the response handshake completes.
- Simultaneous requests: only one grant per IDLE cycle. Losers keep `req_valid` high and are served in rotation order with no starvation; the worst-case wait is NREQ−1 operations.
- Response backpressure: `rsp_ready` low stalls in RESP indefinitely. No further counter pulses are issued while stalled.

## Test plan
- **Reset then single up:** reset; req_valid[0]=1, dir=1 → req_ready[0] same cycle; cnt_up for exactly 1 cycle; rsp_id=0, rsp_count=1.
- **Wrap both ways:**
  - 7 ups from requester 1 → rsp_count sequence 1..7.
  - An 8th up → 0.
  - Then one down → 7, with a cnt_down pulse.
- **Contention:** requesters 0–3 all valid continuously, rsp_ready=1 → grants 0,1,2,3,0…, one every 3 cycles; rsp_id matches grant order; never two req_ready bits high.
- **Backpressure:** hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_id, rsp_count stable; no cnt_up/cnt_down; no req_ready; completes on the first rsp_ready=1.
- **Mid-operation reset:** assert reset in the ISSUE cycle → next cycle state IDLE, shadow=0, rsp_valid=0; the next grant goes to requester 0.
- **Mixed directions:** req 2 down then req 3 up from shadow=0 → responses 7 then 0; pulses are cnt_down then cnt_up, never overlapping.
